fp_mul_operand_feeder: RTL and testbench

Elastic operand front-end and result capture stage for the combinational floating-point multiplier. It accepts IEEE-754 single-precision operand pairs over a valid/ready handshake and buffers them in a small FIFO. The FIFO head drives the multiplier's A/B inputs, and the block registers the returned product onto a valid/ready output port. It also classifies special operands (zero, denormal, infinity, NaN), which the multiplier does not handle.

---
 rtl/fp_mul_operand_feeder.sv | 154 +++++++++++++++
 tb/tb_fp_mul_operand_feeder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_operand_feeder.sv
// fp_mul_operand_feeder
//   Elastic operand FIFO in front of a combinational FP32 multiplier. The
//   returned product is captured into a valid/ready output register.
//   Optional build macro: FP_SPECIAL_CASE_EN. When defined, operands are
//   classified and special results (NaN/Inf/zero) override the multiplier.
//
//   Output FSM:
//   state   | meaning
//   S_EMPTY | result register empty, o_out_valid = 0
//   S_FULL  | result register holds a product, o_out_valid = 1
module fp_mul_operand_feeder #(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [31:0]            i_in_a,
  input  logic [31:0]            i_in_b,
  output logic [31:0]            o_mul_a,
  output logic [31:0]            o_mul_b,
  input  logic [31:0]            i_mul_p,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [31:0]            o_out_p,
  output logic [3:0]             o_out_flags,
  output logic [$clog2(DEPTH):0] o_fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  state_t        r_state;
  state_t        w_next;
  logic [31:0]   r_out_p;
  logic [3:0]    r_out_flags;

  logic          w_push;
  logic          w_pop;
  logic          w_nonempty;
  logic [63:0]   w_head;
  logic [31:0]   w_load_p;
  logic [3:0]    w_flags;

  assign w_nonempty   = (r_count != '0);
  assign o_in_ready   = (r_count != CNT_FULL);
  assign w_push       = i_in_valid && o_in_ready;
  assign w_pop        = w_nonempty && (!o_out_valid || i_out_ready);
  assign w_head       = r_mem[r_rd_ptr];
  assign o_mul_a      = w_nonempty ? w_head[63:32] : 32'h0;
  assign o_mul_b      = w_nonempty ? w_head[31:0]  : 32'h0;
  assign o_fifo_count = r_count;
  assign o_out_p      = r_out_p;
  assign o_out_flags  = r_out_flags;

`ifdef FP_SPECIAL_CASE_EN
  // {nan, inf, zero, denorm} of a single operand
  function automatic logic [3:0] classify(input logic [31:0] x);
    logic e_zero, e_max, m_zero;
    e_zero = (x[30:23] == 8'h00);
    e_max  = (x[30:23] == 8'hFF);
    m_zero = (x[22:0] == 23'h0);
    return {e_max && !m_zero, e_max && m_zero, e_zero && m_zero, e_zero && !m_zero};
  endfunction

  logic [3:0] w_cls_a;
  logic [3:0] w_cls_b;
  logic       w_sign;

  assign w_cls_a = classify(w_head[63:32]);
  assign w_cls_b = classify(w_head[31:0]);
  assign w_sign  = w_head[63] ^ w_head[31];

  // Combine operand classes; inf times zero/denorm is invalid, so it reports nan
  always_comb begin
    w_flags    = w_cls_a | w_cls_b;
    w_flags[3] = w_flags[3]
               | (w_cls_a[2] & (w_cls_b[1] | w_cls_b[0]))
               | (w_cls_b[2] & (w_cls_a[1] | w_cls_a[0]));
  end

  // Special-result override, denormals flushed to signed zero
  always_comb begin
    w_load_p = i_mul_p;
    if (w_flags[3])
      w_load_p = 32'h7FC0_0000;
    else if (w_flags[2])
      w_load_p = {w_sign, 8'hFF, 23'h0};
    else if (w_flags[1] || w_flags[0])
      w_load_p = {w_sign, 31'h0};
  end
`else
  assign w_flags  = 4'h0;
  assign w_load_p = i_mul_p;
`endif

  // Operand storage; occupancy gates validity, so no reset is needed here
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_in_a, i_in_b};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Output FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_EMPTY;
    else       r_state <= w_next;
  end

  // Output FSM next state: a pop always (re)fills the register
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_EMPTY: if (w_pop) w_next = S_FULL;
      S_FULL:  if (i_out_ready && !w_pop) w_next = S_EMPTY;
      default: w_next = S_EMPTY;
    endcase
  end

  // Output FSM outputs
  always_comb begin
    o_out_valid = (r_state == S_FULL);
  end

  // Result register loads on every pop and otherwise holds
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_p     <= 32'h0;
      r_out_flags <= 4'h0;
    end else if (w_pop) begin
      r_out_p     <= w_load_p;
      r_out_flags <= w_flags;
    end
  end

endmodule

// File: tb/tb_fp_mul_operand_feeder.sv
// Scoreboard bench for fp_mul_operand_feeder (DEPTH = 4).
// A truncating behavioural FP32 multiplier stands in for the real one.
module tb_fp_mul_operand_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0, in_b = '0;
  logic [31:0] mul_a, mul_b, mul_p;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_p;
  logic [3:0]  out_flags;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  int n_acc    = 0;
  logic [35:0] sb[$];

  always #5 clk = ~clk;

  fp_mul_operand_feeder #(.DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_a(in_a), .i_in_b(in_b), .o_mul_a(mul_a), .o_mul_b(mul_b),
    .i_mul_p(mul_p), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_p(out_p), .o_out_flags(out_flags), .o_fifo_count(fifo_count)
  );

  // Normal-number multiply with truncation; garbage-in/garbage-out for specials
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    int          e;
    logic [31:0] ev;
    logic [22:0] f;
    m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (m[47]) begin e = e + 1; f = m[46:24]; end
    else f = m[45:23];
    ev = e;
    return {a[31] ^ b[31], ev[7:0], f};
  endfunction

  assign mul_p = fmul(mul_a, mul_b);

  // Reference: {product, flags} expected for an accepted pair
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
    int  ea, eb;
    bit  za, zb, da, db, ia, ib, na, nb, nan, inf, zero, den;
    logic s;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    za = (ea == 0)   && (a[22:0] == 0);  zb = (eb == 0)   && (b[22:0] == 0);
    da = (ea == 0)   && (a[22:0] != 0);  db = (eb == 0)   && (b[22:0] != 0);
    ia = (ea == 255) && (a[22:0] == 0);  ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0);  nb = (eb == 255) && (b[22:0] != 0);
    s  = a[31] ^ b[31];
    nan  = na || nb || (ia && (zb || db)) || (ib && (za || da));
    inf  = ia || ib;
    zero = za || zb;
    den  = da || db;
`ifdef FP_SPECIAL_CASE_EN
    if (nan)              return {32'h7FC00000, 4'b1000 | {1'b0, inf, zero, den}};
    if (inf)              return {s, 8'hFF, 23'h0, nan, inf, zero, den};
    if (zero || den)      return {s, 31'h0, nan, inf, zero, den};
    return {fmul(a, b), nan, inf, zero, den};
`else
    return {fmul(a, b), 4'h0};
`endif
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(7))
      0: r[30:0] = '0;
      1: r[30:23] = 8'h00;
      2: begin r[30:23] = 8'hFF; r[22:0] = '0; end
      3: r[30:23] = 8'hFF;
      default: r[30:23] = 8'($urandom_range(190, 64));
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; called at posedge+1, returns at next posedge+1
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic rdy, output logic acc);
    in_valid = v; in_a = a; in_b = b; out_ready = rdy;
    @(negedge clk);
    acc = v && in_ready;
    if (acc) begin sb.push_back(model(a, b)); n_acc++; end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, rdy, acc);
  endtask

  // Directed pair: checks latency and the exact result
  task automatic single(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_p, input logic [3:0] exp_f);
    logic acc;
    idle(2, 1'b1);
    cycle(1'b1, a, b, 1'b1, acc);
    chk({name, " accept"}, {35'h0, acc}, 36'h1);
    in_valid = 1'b0;
    chk({name, " mul_a"}, {4'h0, mul_a}, {4'h0, a});
    chk({name, " mul_b"}, {4'h0, mul_b}, {4'h0, b});
    chk({name, " valid N"}, {35'h0, out_valid}, 36'h0);
    @(posedge clk); #1;
    chk({name, " valid N+1"}, {35'h0, out_valid}, 36'h1);
    chk({name, " result"}, {out_p, out_flags}, {exp_p, exp_f});
    idle(1, 1'b1);
  endtask

  // Monitor: pops the scoreboard on each output handshake, checks hold stability
  logic        prev_hold = 1'b0;
  logic [35:0] prev_val;
  always @(negedge clk) begin
    if (rst) prev_hold <= 1'b0;
    else begin
      if (prev_hold) chk("hold stable", {out_p, out_flags}, prev_val);
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) chk("unexpected output", {out_p, out_flags}, 36'hx);
        else chk("scoreboard", {out_p, out_flags}, sb.pop_front());
      end
      prev_hold <= out_valid && !out_ready;
      prev_val  <= {out_p, out_flags};
    end
  end

  initial begin
    logic        acc;
    int          k, n0, bound;
    logic [31:0] pa[6], pb[6];

    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready",  {35'h0, in_ready},  36'h1);
    chk("reset out_valid", {35'h0, out_valid}, 36'h0);
    chk("reset out",       {out_p, out_flags}, 36'h0);
    chk("reset count",     {33'h0, fifo_count}, 36'h0);
    chk("reset mul",       {4'h0, mul_a | mul_b}, 36'h0);
    rst = 1'b0;
    idle(1, 1'b1);

`ifdef FP_SPECIAL_CASE_EN
    single("1.5x2",   32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
    single("2x0",     32'h40000000, 32'h00000000, 32'h00000000, 4'b0010);
    single("infx-1",  32'h7F800000, 32'hBF800000, 32'hFF800000, 4'b0100);
    single("infx0",   32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1110);
`else
    single("1.5x2",   32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
    single("2x0 raw", 32'h40000000, 32'h00000000, 32'h00800000, 4'b0000);
`endif

    // Stream of 8 at full rate
    n0 = n_out;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, rand_fp(), rand_fp(), 1'b1, acc);
      chk("stream count<=1", {35'h0, fifo_count <= 3'd1}, 36'h1);
      if (i > 0) chk("stream back-to-back", {35'h0, out_valid}, 36'h1);
    end
    idle(3, 1'b1);
    chk("stream outputs", 36'(n_out - n0), 36'd8);

    // Backpressure: 6 pairs offered with out_ready low
    for (int i = 0; i < 6; i++) begin pa[i] = rand_fp(); pb[i] = rand_fp(); end
    k = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, pa[k], pb[k], 1'b0, acc);
      if (acc) k++;
    end
    chk("bp accepted", 36'(k), 36'd5);
    chk("bp in_ready", {35'h0, in_ready}, 36'h0);
    chk("bp count", {33'h0, fifo_count}, 36'd4);
    for (int i = 0; i < 3; i++) cycle(1'b1, pa[5], pb[5], 1'b0, acc);
    chk("bp still blocked", {35'h0, acc}, 36'h0);
    bound = 0;
    acc = 1'b0;
    while (!acc && bound < 10) begin
      cycle(1'b1, pa[5], pb[5], 1'b1, acc);
      bound++;
    end
    chk("bp 6th accepted", {35'h0, acc}, 36'h1);
    idle(8, 1'b1);

    // Reset with 3 buffered entries and a held result
    for (int i = 0; i < 4; i++) cycle(1'b1, rand_fp(), rand_fp(), 1'b0, acc);
    in_valid = 1'b0;
    chk("pre-reset count", {33'h0, fifo_count}, 36'd3);
    chk("pre-reset valid", {35'h0, out_valid}, 36'h1);
    #2 rst = 1'b1;
    #1;
    chk("async rst valid", {35'h0, out_valid}, 36'h0);
    chk("async rst out",   {out_p, out_flags}, 36'h0);
    chk("async rst count", {33'h0, fifo_count}, 36'h0);
    chk("async rst ready", {35'h0, in_ready}, 36'h1);
    chk("async rst mul",   {4'h0, mul_a | mul_b}, 36'h0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2, 1'b1);
    chk("post-reset valid", {35'h0, out_valid}, 36'h0);
    chk("post-reset count", {33'h0, fifo_count}, 36'h0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(3) != 0, rand_fp(), rand_fp(), $urandom_range(2) != 0, acc);

    // Drain
    in_valid = 1'b0;
    bound = 0;
    while ((sb.size() != 0 || out_valid) && bound < 50) begin
      idle(1, 1'b1);
      bound++;
    end
    chk("drain complete", 36'(sb.size()), 36'd0);
    chk("drain valid", {35'h0, out_valid}, 36'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
